// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and constants for the fetch stage
package mips_pkg;

  typedef enum logic [1:0] {
    BAJ_SEQ = 2'b00,
    BAJ_BR  = 2'b01,
    BAJ_J   = 2'b10,
    BAJ_JR  = 2'b11
  } baj_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] COUNT_MAX        = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// rtl/fetch_redirect_unit_if.sv - ID-side control inputs, imem port and fetch-stage outputs
interface fetch_redirect_unit_if;

  logic        Stall;
  logic [1:0]  BranchAndJump;
  logic [31:0] BranchImm;
  logic [25:0] JumpIndex;
  logic [31:0] RegA;
  logic [31:0] InstrIn;
  logic [31:0] PC;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPCPlus4;
  logic        IfIdValid;
  logic [31:0] RedirectCount;
  logic        Misaligned;

  // Driver side: hazard unit, ID stage and instruction memory
  modport master (
    output Stall, BranchAndJump, BranchImm, JumpIndex, RegA, InstrIn,
    input  PC, IfIdInstr, IfIdPCPlus4, IfIdValid, RedirectCount, Misaligned
  );

  // Fetch unit side
  modport slave (
    input  Stall, BranchAndJump, BranchImm, JumpIndex, RegA, InstrIn,
    output PC, IfIdInstr, IfIdPCPlus4, IfIdValid, RedirectCount, Misaligned
  );

endinterface

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - redirect target address and jr alignment check
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [1:0]  BranchAndJump,
  input  logic [31:0] IfIdPCPlus4,
  input  logic [31:0] BranchImm,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegA,
  output logic [31:0] target,
  output logic        misaligned
);

  // Select the target for the ID decision; low jr bits are dropped but flagged
  always_comb begin
    target     = IfIdPCPlus4;
    misaligned = 1'b0;
    case (baj_e'(BranchAndJump))
      BAJ_SEQ: target = IfIdPCPlus4;
      BAJ_BR:  target = IfIdPCPlus4 + (BranchImm << 2);
      BAJ_J:   target = {IfIdPCPlus4[31:28], JumpIndex, 2'b00};
      BAJ_JR: begin
        target     = {RegA[31:2], 2'b00};
        misaligned = (RegA[1:0] != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC and IF/ID register with squashing redirects
module fetch_redirect_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  Clk,
  input  logic                  Reset,
  fetch_redirect_unit_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] redirect_count_q, redirect_count_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] target;
  logic        jr_misaligned;
  logic        redirect;
  logic [31:0] pc_plus4;

  pc_target_calc u_target (
    .BranchAndJump (bus.BranchAndJump),
    .IfIdPCPlus4   (pcp4_q),
    .BranchImm     (bus.BranchImm),
    .JumpIndex     (bus.JumpIndex),
    .RegA          (bus.RegA),
    .target        (target),
    .misaligned    (jr_misaligned)
  );

  // A decision seen while ID holds a bubble is stale and must be ignored
  assign redirect = valid_q && (bus.BranchAndJump != BAJ_SEQ);
  assign pc_plus4 = pc_q + 32'd4;

  // Next state: stall freezes everything, redirect squashes, else fetch sequentially
  always_comb begin
    pc_d             = pc_q;
    instr_d          = instr_q;
    pcp4_d           = pcp4_q;
    valid_d          = valid_q;
    redirect_count_d = redirect_count_q;
    misaligned_d     = misaligned_q;
    if (!bus.Stall) begin
      if (redirect) begin
        pc_d             = target;
        instr_d          = NOP_INSTR;
        pcp4_d           = 32'd0;
        valid_d          = 1'b0;
        redirect_count_d = (redirect_count_q == COUNT_MAX) ? redirect_count_q
                                                           : redirect_count_q + 32'd1;
        misaligned_d     = misaligned_q | jr_misaligned;
      end else begin
        pc_d    = pc_plus4;
        instr_d = bus.InstrIn;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q             <= RESET_PC;
      instr_q          <= NOP_INSTR;
      pcp4_q           <= 32'd0;
      valid_q          <= 1'b0;
      redirect_count_q <= 32'd0;
      misaligned_q     <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      instr_q          <= instr_d;
      pcp4_q           <= pcp4_d;
      valid_q          <= valid_d;
      redirect_count_q <= redirect_count_d;
      misaligned_q     <= misaligned_d;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.IfIdInstr     = instr_q;
  assign bus.IfIdPCPlus4   = pcp4_q;
  assign bus.IfIdValid     = valid_q;
  assign bus.RedirectCount = redirect_count_q;
  assign bus.Misaligned    = misaligned_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed scoreboard bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

  logic Clk;
  logic Reset;

  fetch_redirect_unit_if bus();

  fetch_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h2008_0001;
  endfunction

  assign bus.InstrIn = imem(bus.PC);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
  logic        m_valid, m_mis;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
    m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"},    bus.PC, 32'h0);
    chk({tag, "_instr"}, bus.IfIdInstr, 32'h0);
    chk({tag, "_pcp4"},  bus.IfIdPCPlus4, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.IfIdValid}, 32'h0);
    chk({tag, "_cnt"},   bus.RedirectCount, 32'h0);
    chk({tag, "_mis"},   {31'b0, bus.Misaligned}, 32'h0);
  endtask

  // Reference behaviour of one rising edge, from the bench's own state
  task automatic model_edge();
    exp_t e;
    logic [31:0] tgt;
    if (!bus.Stall) begin
      if (m_valid && bus.BranchAndJump != 2'b00) begin
        case (bus.BranchAndJump)
          2'b01:   tgt = m_pcp4 + {bus.BranchImm[29:0], 2'b00};
          2'b10:   tgt = {m_pcp4[31:28], bus.JumpIndex, 2'b00};
          default: tgt = {bus.RegA[31:2], 2'b00};
        endcase
        if (bus.BranchAndJump == 2'b11 && bus.RegA[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = tgt; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_instr = imem(m_pc);
        m_pcp4  = m_pc + 4;
        m_pc    = m_pc + 4;
        m_valid = 1'b1;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4;
    e.valid = m_valid; e.cnt = m_cnt; e.mis = m_mis;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("pc",    bus.PC, e.pc);
      chk("instr", bus.IfIdInstr, e.instr);
      chk("pcp4",  bus.IfIdPCPlus4, e.pcp4);
      chk("valid", {31'b0, bus.IfIdValid}, {31'b0, e.valid});
      chk("cnt",   bus.RedirectCount, e.cnt);
      chk("mis",   {31'b0, bus.Misaligned}, {31'b0, e.mis});
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clk);
    #1;
    check_pop();
  endtask

  task automatic drive(input logic [1:0] baj);
    bus.BranchAndJump = baj;
  endtask

  initial begin
    Reset = 1'b1;
    bus.Stall = 1'b0;
    bus.BranchAndJump = 2'b00;
    bus.BranchImm = 32'h0;
    bus.JumpIndex = 26'h0;
    bus.RegA = 32'h0;
    model_reset();

    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Reset = 1'b0;
    #1;
    chk("release_pc", bus.PC, 32'h0);
    chk("release_valid", {31'b0, bus.IfIdValid}, 32'h0);

    // First fetch and three more sequential steps
    cycle();
    chk("first_instr", bus.IfIdInstr, 32'h2008_0001);
    chk("first_pc", bus.PC, 32'h4);
    repeat (3) cycle();
    chk("pcp4_0x10", bus.IfIdPCPlus4, 32'h10);

    // Taken backward branch
    drive(2'b01); bus.BranchImm = 32'hFFFF_FFFE;
    cycle();
    chk("br_pc", bus.PC, 32'h8);
    chk("br_bubble", {31'b0, bus.IfIdValid}, 32'h0);
    chk("br_cnt", bus.RedirectCount, 32'h1);
    // Decision held during the bubble must be ignored
    cycle();
    chk("br_target_valid", {31'b0, bus.IfIdValid}, 32'h1);
    chk("br_target_instr", bus.IfIdInstr, imem(32'h8));

    // Aligned jr to set up the j test
    drive(2'b11); bus.RegA = 32'h4000_0004;
    cycle();
    chk("jr_pc", bus.PC, 32'h4000_0004);
    drive(2'b00);
    cycle();
    chk("j_setup_pcp4", bus.IfIdPCPlus4, 32'h4000_0008);
    drive(2'b10); bus.JumpIndex = 26'h000_0040;
    cycle();
    chk("j_pc", bus.PC, 32'h4000_0100);
    drive(2'b00);
    cycle();

    // Stall with a pending j
    drive(2'b10); bus.JumpIndex = 26'h000_0080; bus.Stall = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_pc", bus.PC, 32'h4000_0104);
      chk("stall_cnt", bus.RedirectCount, 32'h3);
    end
    bus.Stall = 1'b0;
    cycle();
    chk("unstall_pc", bus.PC, 32'h4000_0200);
    chk("unstall_cnt", bus.RedirectCount, 32'h4);
    drive(2'b00);
    cycle();

    // Misaligned jr is sticky
    drive(2'b11); bus.RegA = 32'h0000_0203;
    cycle();
    chk("jr_mis_pc", bus.PC, 32'h200);
    chk("jr_mis_flag", {31'b0, bus.Misaligned}, 32'h1);
    drive(2'b00);
    repeat (10) cycle();
    chk("mis_sticky", {31'b0, bus.Misaligned}, 32'h1);

    // Counter saturation
    force dut.redirect_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.redirect_count_q;
    m_cnt = 32'hFFFF_FFFE;
    chk("sat_preload", bus.RedirectCount, 32'hFFFF_FFFE);
    drive(2'b01); bus.BranchImm = 32'h4;
    cycle();
    chk("sat_max", bus.RedirectCount, 32'hFFFF_FFFF);
    cycle();
    cycle();
    chk("sat_hold", bus.RedirectCount, 32'hFFFF_FFFF);
    drive(2'b00);
    cycle();

    // Asynchronous reset with a redirect pending
    drive(2'b10); bus.JumpIndex = 26'h000_0123;
    #3;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge Clk);
    #1;
    check_reset_outputs("reset_hold");
    sb.delete();
    model_reset();
    drive(2'b00);
    Reset = 1'b0;
    #1;
    chk("rerelease_valid", {31'b0, bus.IfIdValid}, 32'h0);
    cycle();
    chk("refetch_instr", bus.IfIdInstr, 32'h2008_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
